uart_rx_byte: RTL and testbench

- UART receiver inside top_sub that consumes the raw UART_RX pin.
- Emits whole bytes over a valid/ready interface to the program/data loader, which writes instruction and data memory.
- Frame format: 8N1, idle-high line, fixed bit period in clock cycles.
- Bit order is selectable; MSB-first is the host loader's wire format.

---
 rtl/uart_pkg.sv | 18 +
 rtl/bit_sync.sv | 25 ++
 rtl/uart_rx_byte.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_byte.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receive path and future transmit/loopback blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int DEFAULT_CLK_PER_BIT = 1992;

  function automatic int half_bit(input int clk_per_bit);
    return clk_per_bit / 2;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous input; resets to RESET_VAL.
module bit_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the raw input through the synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver delivering whole bytes over valid/ready, with sticky framing and overrun flags.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err,
  output logic       busy
);

  localparam int            CW      = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(half_bit(CLK_PER_BIT) - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);

  rx_state_t     state_r, state_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [2:0]    idx_r, idx_n;
  logic [7:0]    shift_r, shift_n;
  logic [7:0]    rx_data_r, rx_data_n;
  logic          rx_valid_r, rx_valid_n;
  logic          frame_err_r, frame_err_n;
  logic          overrun_r, overrun_n;
  logic          busy_r;
  logic          rx_s, handshake_s, take_s, ferr_set_s, ovr_set_s;
  logic [2:0]    slot_s;

  bit_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_sync (
    .clk(CLK),
    .rst(RST),
    .d  (UART_RX),
    .q  (rx_s)
  );

  assign handshake_s = rx_valid_r & rx_ready;
  assign slot_s      = MSB_FIRST ? (3'd7 - idx_r) : idx_r;

  // Next-state, sampling and output-update logic
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r + CW'(1);
    idx_n      = idx_r;
    shift_n    = shift_r;
    take_s     = 1'b0;
    ferr_set_s = 1'b0;
    ovr_set_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_n = '0;
        idx_n = 3'd0;
        if (!rx_s) state_n = START;
        else       state_n = IDLE;
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_n = '0;
          if (rx_s) state_n = IDLE;
          else      state_n = DATA;
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_n           = '0;
          shift_n[slot_s] = rx_s;
          idx_n           = idx_r + 3'd1;
          if (idx_r == 3'd7) state_n = STOP;
          else               state_n = DATA;
        end else begin
          state_n = DATA;
        end
      end
      STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
            // A consumer handshake in the same cycle frees the slot for the new byte
            if (!rx_valid_r || handshake_s) take_s = 1'b1;
            else                            ovr_set_s = 1'b1;
          end else begin
            state_n    = BREAK;
            ferr_set_s = 1'b1;
          end
        end else begin
          state_n = STOP;
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
        else      state_n = BREAK;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = 3'd0;
      end
    endcase

    if (take_s) begin
      rx_data_n  = shift_r;
      rx_valid_n = 1'b1;
    end else begin
      rx_data_n  = rx_data_r;
      rx_valid_n = rx_valid_r & ~rx_ready;
    end

    if (clr_err) begin
      frame_err_n = 1'b0;
      overrun_n   = 1'b0;
    end else begin
      frame_err_n = frame_err_r | ferr_set_s;
      overrun_n   = overrun_r | ovr_set_s;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      idx_r       <= 3'd0;
      shift_r     <= 8'h00;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      idx_r       <= idx_n;
      shift_r     <= shift_n;
      rx_data_r   <= rx_data_n;
      rx_valid_r  <= rx_valid_n;
      frame_err_r <= frame_err_n;
      overrun_r   <= overrun_n;
      busy_r      <= (state_n != IDLE);
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: three instances cover MSB-first, LSB-first and full-rate timing.
module tb_uart_rx_byte;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
  logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
  logic [7:0] data_a, data_b, data_c;
  logic valid_a, valid_b, valid_c;
  logic ferr_a, ferr_b, ferr_c;
  logic ovr_a, ovr_b, ovr_c;
  logic busy_a, busy_b, busy_c;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int vcnt_a = 0, vcnt_b = 0;
  int rise_a = -1, rise_c = -1;
  logic prev_a = 1'b0, prev_c = 1'b0;
  int t0, v0;

  always #5 clk = ~clk;

  uart_rx_byte #(.CLK_PER_BIT(16), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_a (
    .CLK(clk), .RST(rst), .UART_RX(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(rdy_a), .frame_err(ferr_a), .overrun(ovr_a), .clr_err(clr_a), .busy(busy_a));

  uart_rx_byte #(.CLK_PER_BIT(16), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_b (
    .CLK(clk), .RST(rst), .UART_RX(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(rdy_b), .frame_err(ferr_b), .overrun(ovr_b), .clr_err(clr_b), .busy(busy_b));

  uart_rx_byte #(.CLK_PER_BIT(1992), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_c (
    .CLK(clk), .RST(rst), .UART_RX(rx_c), .rx_data(data_c), .rx_valid(valid_c),
    .rx_ready(rdy_c), .frame_err(ferr_c), .overrun(ovr_c), .clr_err(clr_c), .busy(busy_c));

  // Posedge counter used as the timebase for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  // Track rx_valid high-cycle counts and rising-edge cycle numbers
  always @(negedge clk) begin
    if (valid_a) vcnt_a <= vcnt_a + 1;
    if (valid_b) vcnt_b <= vcnt_b + 1;
    if (valid_a && !prev_a) rise_a <= cyc;
    if (valid_c && !prev_c) rise_c <= cyc;
    prev_a <= valid_a;
    prev_c <= valid_c;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int d, input logic v);
    case (d)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Sends start, w[7] first .. w[0], then stop; only the first 'slots' bit times are driven
  task automatic send(input int d, input int cpb, input logic [7:0] w, input logic stop, input int slots);
    logic [9:0] f;
    f = {1'b0, w, stop};
    for (int i = 0; i < slots; i++) begin
      set_line(d, f[9-i]);
      repeat (cpb) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_data",  {24'd0, data_a}, 32'h00);
    check("reset_valid", {31'd0, valid_a}, 32'd0);
    check("reset_ferr",  {31'd0, ferr_a}, 32'd0);
    check("reset_ovr",   {31'd0, ovr_a}, 32'd0);
    check("reset_busy",  {31'd0, busy_a}, 32'd0);

    // Single frame 0xA5, MSB first
    t0 = cyc; v0 = vcnt_a;
    send(0, 16, 8'hA5, 1'b1, 10);
    repeat (10) @(negedge clk);
    check("a5_data",    {24'd0, data_a}, 32'hA5);
    check("a5_pulse",   vcnt_a - v0, 32'd1);
    check("a5_latency", rise_a - t0, 32'd155);
    check("a5_busy",    {31'd0, busy_a}, 32'd0);

    // LSB-first instance
    send(1, 16, 8'hA5, 1'b1, 10);
    repeat (10) @(negedge clk);
    check("lsb_a5_data", {24'd0, data_b}, 32'hA5);
    v0 = vcnt_b;
    send(1, 16, 8'h01, 1'b1, 10);
    repeat (10) @(negedge clk);
    check("lsb_01_data",  {24'd0, data_b}, 32'h80);
    check("lsb_01_pulse", vcnt_b - v0, 32'd1);

    // Glitch shorter than half a bit
    v0 = vcnt_a;
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_hi", {31'd0, busy_a}, 32'd1);
    rx_a = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_lo", {31'd0, busy_a}, 32'd0);
    check("glitch_novalid", vcnt_a - v0, 32'd0);
    check("glitch_ferr",    {31'd0, ferr_a}, 32'd0);
    check("glitch_ovr",     {31'd0, ovr_a}, 32'd0);

    // Stop bit low followed by a long break
    v0 = vcnt_a;
    send(0, 16, 8'h5A, 1'b0, 10);
    repeat (100) @(negedge clk);
    check("break_busy", {31'd0, busy_a}, 32'd1);
    check("break_ferr", {31'd0, ferr_a}, 32'd1);
    rx_a = 1'b1;
    repeat (10) @(negedge clk);
    check("break_idle",    {31'd0, busy_a}, 32'd0);
    check("break_novalid", vcnt_a - v0, 32'd0);
    check("break_data",    {24'd0, data_a}, 32'hA5);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("ferr_cleared", {31'd0, ferr_a}, 32'd0);

    // Overrun with the consumer stalled
    rdy_a = 1'b0;
    send(0, 16, 8'h3C, 1'b1, 10);
    send(0, 16, 8'hC3, 1'b1, 10);
    repeat (10) @(negedge clk);
    check("ovr_data",  {24'd0, data_a}, 32'h3C);
    check("ovr_valid", {31'd0, valid_a}, 32'd1);
    check("ovr_flag",  {31'd0, ovr_a}, 32'd1);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    check("ovr_drain", {31'd0, valid_a}, 32'd0);
    rdy_a = 1'b1;
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("ovr_cleared", {31'd0, ovr_a}, 32'd0);

    // Reset in the middle of frame 0x55, then a clean 0x0F
    v0 = vcnt_a;
    send(0, 16, 8'h55, 1'b1, 5);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy",  {31'd0, busy_a}, 32'd0);
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    rx_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send(0, 16, 8'h0F, 1'b1, 10);
    repeat (10) @(negedge clk);
    check("rst_one_byte", vcnt_a - v0, 32'd1);
    check("rst_data",     {24'd0, data_a}, 32'h0F);

    // Full-rate timing at 1992 clocks per bit
    t0 = cyc;
    send(2, 1992, 8'h7E, 1'b1, 10);
    repeat (10) @(negedge clk);
    check("c_data",    {24'd0, data_c}, 32'h7E);
    check("c_latency", rise_c - t0, 32'd18927);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
